picomips_decode_stage: RTL

Registered, handshaked instruction-decode stage for the pipelined picoMIPS core, sitting between fetch and execute. It generalises the combinational decoder in three ways: configurable widths, an internal flag register, and a flag-hazard scoreboard. Conditional branches resolve against committed flags only, stalling while flag-setting instructions are still in flight, and a taken branch produces a one-cycle flush of the wrong-path instruction.

---
 rtl/picomips_pkg.sv | 43 ++++
 rtl/picomips_decode_stage_if.sv | 34 +++
 rtl/picomips_decode_stage_branch_cond.sv | 21 ++
 rtl/picomips_decode_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode and ALU encodings, flag bit positions
// and opcode-class helpers used by the decode stage and its branch evaluator.
package picomips_pkg;

    localparam int OPC_W       = 6;
    localparam int FLAG_N      = 4;
    localparam int ALU_W       = 3;
    localparam int MAXPEND_DEF = 3;

    // Flag vector bit order is {V,N,Z,C}
    localparam int FV = 3;
    localparam int FN = 2;
    localparam int FZ = 1;
    localparam int FC = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_ADDI = 6'd2,
        OP_SUB  = 6'd3,
        OP_SUBI = 6'd4,
        OP_J    = 6'd5,
        OP_BEQ  = 6'd6,
        OP_BNE  = 6'd7,
        OP_BGE  = 6'd8,
        OP_BLO  = 6'd9
    } opcode_e;

    typedef enum logic [ALU_W-1:0] {
        RNOP = 3'b000,
        RADD = 3'b010,
        RSUB = 3'b011
    } alu_e;

    function automatic logic is_flagset(opcode_e op);
        return op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI};
    endfunction

    function automatic logic is_branch(opcode_e op);
        return op inside {OP_BEQ, OP_BNE, OP_BGE, OP_BLO};
    endfunction

endpackage

// File: rtl/picomips_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the picoMIPS decode stage.
interface picomips_decode_stage_if #(
    parameter int OPW = 6,
    parameter int NF  = 4,
    parameter int AFW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] opcode;
    logic [NF-1:0]  alu_flags;
    logic           flags_we;
    logic           out_valid;
    logic           out_ready;
    logic [AFW-1:0] ALUfunc;
    logic           imm;
    logic           w;
    logic           PCincr;
    logic           PCabsbranch;
    logic           PCrelbranch;
    logic           flush;
    logic           illegal;

    modport slave (
        input  in_valid, opcode, alu_flags, flags_we, out_ready,
        output in_ready, out_valid, ALUfunc, imm, w,
               PCincr, PCabsbranch, PCrelbranch, flush, illegal
    );

    modport master (
        output in_valid, opcode, alu_flags, flags_we, out_ready,
        input  in_ready, out_valid, ALUfunc, imm, w,
               PCincr, PCabsbranch, PCrelbranch, flush, illegal
    );
endinterface

// File: rtl/picomips_decode_stage_branch_cond.sv
// Conditional-branch evaluator: resolves a branch opcode against committed flags.
module branch_cond
    import picomips_pkg::*;
#(
    parameter int NF = FLAG_N
) (
    input  opcode_e       op,
    input  logic [NF-1:0] flags,
    output logic          taken
);
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = flags[FZ];
            OP_BNE:  taken = ~flags[FZ];
            OP_BGE:  taken = (flags[FN] == flags[FV]);
            OP_BLO:  taken = flags[FC];
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/picomips_decode_stage.sv
// Registered picoMIPS decode stage with committed flag register, flag-hazard
// scoreboard and one-cycle wrong-path flush after a redirect.
module picomips_decode_stage
    import picomips_pkg::*;
#(
    parameter int OPW     = OPC_W,
    parameter int NF      = FLAG_N,
    parameter int AFW     = ALU_W,
    parameter int MAXPEND = MAXPEND_DEF
) (
    input logic                    clk,
    input logic                    reset,
    picomips_decode_stage_if.slave bus
);
    localparam int PW = $clog2(MAXPEND + 1);

    opcode_e        op_in;
    logic           legal_in, taken, hazard, in_ready, accept, handoff, held_fs;
    logic [PW:0]    pend_eff;
    logic           pend_inc, pend_dec;

    logic [AFW-1:0] dec_alu;
    logic           dec_imm, dec_w, dec_inc, dec_abs, dec_rel;

    logic           out_valid_q, out_valid_d;
    logic [AFW-1:0] alufunc_q, alufunc_d;
    logic           imm_q, imm_d, w_q, w_d;
    logic           pcincr_q, pcincr_d, pcabs_q, pcabs_d, pcrel_q, pcrel_d;
    logic           illegal_q, illegal_d, setflag_q, setflag_d;
    logic [NF-1:0]  flags_q, flags_d;
    logic [PW-1:0]  pend_q, pend_d;
    logic           flush_q, flush_d;

    assign op_in    = opcode_e'(OPC_W'(bus.opcode));
    assign legal_in = (OPW'(op_in) == bus.opcode) &&
                      (op_in inside {OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
                                     OP_J, OP_BEQ, OP_BNE, OP_BGE, OP_BLO});

    branch_cond #(.NF(NF)) u_branch_cond (
        .op    (op_in),
        .flags (flags_q),
        .taken (taken)
    );

    // A flag-setter still parked in the output register counts as in flight,
    // so a following branch cannot slip past it on stale flags.
    always_comb begin
        held_fs  = out_valid_q & setflag_q;
        pend_eff = {1'b0, pend_q} + {{PW{1'b0}}, held_fs};
        hazard   = legal_in &
                   ((is_branch(op_in) & ((pend_eff != '0) | bus.flags_we)) |
                    (is_flagset(op_in) & (pend_eff >= (PW+1)'(MAXPEND))));
        in_ready = (~out_valid_q | bus.out_ready) & ~hazard;
        accept   = bus.in_valid & in_ready;
        handoff  = out_valid_q & bus.out_ready;
    end

    always_comb begin
        dec_alu = AFW'(RNOP);
        dec_imm = 1'b0;
        dec_w   = 1'b0;
        dec_inc = 1'b1;
        dec_abs = 1'b0;
        dec_rel = 1'b0;
        if (legal_in) begin
            case (op_in)
                OP_ADD:  begin dec_alu = AFW'(RADD); dec_w = 1'b1; end
                OP_ADDI: begin dec_alu = AFW'(RADD); dec_w = 1'b1; dec_imm = 1'b1; end
                OP_SUB:  begin dec_alu = AFW'(RSUB); dec_w = 1'b1; end
                OP_SUBI: begin dec_alu = AFW'(RSUB); dec_w = 1'b1; dec_imm = 1'b1; end
                OP_J:    begin dec_inc = 1'b0; dec_abs = 1'b1; end
                OP_BEQ, OP_BNE, OP_BGE, OP_BLO: begin
                    dec_inc = ~taken;
                    dec_rel = taken;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alufunc_d   = alufunc_q;
        imm_d       = imm_q;
        w_d         = w_q;
        pcincr_d    = pcincr_q;
        pcabs_d     = pcabs_q;
        pcrel_d     = pcrel_q;
        illegal_d   = illegal_q;
        setflag_d   = setflag_q;

        if (handoff) out_valid_d = 1'b0;
        // During a flush cycle the accepted instruction is consumed but not issued.
        if (accept && !flush_q) begin
            out_valid_d = 1'b1;
            alufunc_d   = dec_alu;
            imm_d       = dec_imm;
            w_d         = dec_w;
            pcincr_d    = dec_inc;
            pcabs_d     = dec_abs;
            pcrel_d     = dec_rel;
            illegal_d   = ~legal_in;
            setflag_d   = legal_in & is_flagset(op_in);
        end

        flags_d = bus.flags_we ? bus.alu_flags : flags_q;
        flush_d = handoff & (pcrel_q | pcabs_q);

        pend_inc = handoff & setflag_q;
        pend_dec = bus.flags_we & (pend_q != '0);
        pend_d   = pend_q;
        if (pend_inc && !pend_dec)      pend_d = pend_q + PW'(1);
        else if (!pend_inc && pend_dec) pend_d = pend_q - PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alufunc_q   <= '0;
            imm_q       <= 1'b0;
            w_q         <= 1'b0;
            pcincr_q    <= 1'b0;
            pcabs_q     <= 1'b0;
            pcrel_q     <= 1'b0;
            illegal_q   <= 1'b0;
            setflag_q   <= 1'b0;
            flags_q     <= '0;
            pend_q      <= '0;
            flush_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alufunc_q   <= alufunc_d;
            imm_q       <= imm_d;
            w_q         <= w_d;
            pcincr_q    <= pcincr_d;
            pcabs_q     <= pcabs_d;
            pcrel_q     <= pcrel_d;
            illegal_q   <= illegal_d;
            setflag_q   <= setflag_d;
            flags_q     <= flags_d;
            pend_q      <= pend_d;
            flush_q     <= flush_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.ALUfunc     = alufunc_q;
    assign bus.imm         = imm_q;
    assign bus.w           = w_q;
    assign bus.PCincr      = pcincr_q;
    assign bus.PCabsbranch = pcabs_q;
    assign bus.PCrelbranch = pcrel_q;
    assign bus.flush       = flush_q;
    assign bus.illegal     = illegal_q;
endmodule
